// File: rtl/led_pkg.sv
// Shared constants for the LED chaser / fade driver pair, plus the gamma curve.
// Gamma correction in the fade channels is enabled with LED_FADE_GAMMA_EN.
package led_pkg;

    localparam int unsigned PWM_BITS_DEF = 4;
    localparam int unsigned MAX_DEF      = 2 ** PWM_BITS_DEF - 1;
    localparam int unsigned N_LED_DEF    = 8;

    // Rounded square law: (lvl^2 + full/2) / full, so full maps to full and 0 to 0.
    function automatic int unsigned gamma(input int unsigned lvl, input int unsigned full);
        return (lvl * lvl + full / 2) / full;
    endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// Pattern input and PWM/tick outputs of the LED fade driver.
// Feature macro used by this block: LED_FADE_GAMMA_EN.
interface led_fade_driver_if #(
    parameter int unsigned N_LED = led_pkg::N_LED_DEF
);

    logic [N_LED-1:0] led_in;
    logic [N_LED-1:0] led_out;
    logic             frame_tick;
    logic             decay_tick;

    modport master (
        output led_in,
        input  led_out,
        input  frame_tick,
        input  decay_tick
    );

    modport slave (
        input  led_in,
        output led_out,
        output frame_tick,
        output decay_tick
    );

endinterface

// File: rtl/led_fade_channel.sv
// One LED brightness channel: level register with set/decay priority and PWM compare.
// With LED_FADE_GAMMA_EN defined, the level is gamma-mapped through a constant LUT.
module led_fade_channel
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF
) (
    input  logic                clk,
    input  logic                rs,
    input  logic                set,
    input  logic                decay,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                out
);

    localparam logic [PWM_BITS-1:0] MAX = '1;

    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] eff_level;

`ifdef LED_FADE_GAMMA_EN
    logic [PWM_BITS-1:0] gamma_lut [2**PWM_BITS];

    for (genvar g = 0; g < 2 ** PWM_BITS; g++) begin : g_lut
        assign gamma_lut[g] = PWM_BITS'(gamma(g, 2 ** PWM_BITS - 1));
    end

    assign eff_level = gamma_lut[level];
`else
    assign eff_level = level;
`endif

    // A lit input overrides a decay step landing on the same edge.
    always_ff @(posedge clk) begin
        if (rs) begin
            level <= '0;
        end else if (set) begin
            level <= MAX;
        end else if (decay && (level != '0)) begin
            level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            out <= 1'b0;
        end else begin
            out <= (pwm_cnt < eff_level);
        end
    end

endmodule

// File: rtl/led_fade_driver.sv
// PWM afterglow driver for the chaser LEDs: shared frame/decay timing plus N_LED channels.
// Define LED_FADE_GAMMA_EN to gamma-correct channel brightness.
module led_fade_driver
    import led_pkg::*;
#(
    parameter int unsigned PWM_BITS  = PWM_BITS_DEF,
    parameter int unsigned DECAY_DIV = 8,
    parameter int unsigned N_LED     = N_LED_DEF
) (
    input  logic               clk,
    input  logic               rs,
    led_fade_driver_if.slave   bus
);

    localparam int unsigned MAX     = 2 ** PWM_BITS - 1;
    localparam int unsigned FRAME_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

    logic [PWM_BITS-1:0] pwm_cnt;
    logic [FRAME_W-1:0]  frame_cnt;
    logic                frame_tick;
    logic                decay_tick;
    logic                frame_end;
    logic                last_frame;
    logic [N_LED-1:0]    led_out;

    assign frame_end  = (pwm_cnt == PWM_BITS'(MAX - 1));
    assign last_frame = (frame_cnt == FRAME_W'(DECAY_DIV - 1));

    // Ticks are registered, so they land on the cycle where pwm_cnt has wrapped to 0.
    always_ff @(posedge clk) begin
        if (rs) begin
            pwm_cnt    <= '0;
            frame_cnt  <= '0;
            frame_tick <= 1'b0;
            decay_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            decay_tick <= frame_end && last_frame;
            if (frame_end) begin
                pwm_cnt   <= '0;
                frame_cnt <= last_frame ? '0 : frame_cnt + 1'b1;
            end else begin
                pwm_cnt <= pwm_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .clk     (clk),
            .rs      (rs),
            .set     (bus.led_in[i]),
            .decay   (decay_tick),
            .pwm_cnt (pwm_cnt),
            .out     (led_out[i])
        );
    end

    assign bus.led_out    = led_out;
    assign bus.frame_tick = frame_tick;
    assign bus.decay_tick = decay_tick;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver; expected brightness follows LED_FADE_GAMMA_EN.
module tb_led_fade_driver;

    logic clk = 1'b0;
    logic rs  = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   hi [8];
    int   eff [16];

    always #5 clk = ~clk;

    led_fade_driver_if #(.N_LED(8)) bus ();

    led_fade_driver #(
        .PWM_BITS  (4),
        .DECAY_DIV (8),
        .N_LED     (8)
    ) dut (
        .clk (clk),
        .rs  (rs),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Leaves the bench sampling inside the cycle where decay_tick is high.
    task automatic wait_decay();
        int  n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            tick();
            n++;
            seen = bus.decay_tick;
        end
        chk("decay_wait", {31'd0, seen}, 32'd1);
    endtask

    // High cycles per channel over 15 consecutive cycles.
    task automatic measure();
        for (int b = 0; b < 8; b++) hi[b] = 0;
        repeat (15) begin
            tick();
            for (int b = 0; b < 8; b++) hi[b] += int'(bus.led_out[b]);
        end
    endtask

    initial begin
`ifdef LED_FADE_GAMMA_EN
        eff = '{0, 0, 0, 1, 1, 2, 2, 3, 4, 5, 7, 8, 10, 11, 13, 15};
`else
        eff = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
`endif
        bus.led_in = 8'h00;

        // Reset state and free-running tick cadence.
        tick();
        tick();
        chk("rst_led_out", 32'(bus.led_out), 32'h0);
        chk("rst_frame_tick", 32'(bus.frame_tick), 32'd0);
        chk("rst_decay_tick", 32'(bus.decay_tick), 32'd0);
        rs = 1'b0;
        for (int i = 1; i <= 2000; i++) begin
            tick();
            chk("idle_led_out", 32'(bus.led_out), 32'h0);
            chk("idle_frame_tick", 32'(bus.frame_tick), (i % 15 == 0) ? 32'd1 : 32'd0);
            chk("idle_decay_tick", 32'(bus.decay_tick), (i % 120 == 0) ? 32'd1 : 32'd0);
        end

        // Steady on: two-cycle latency, then continuous on through decay ticks.
        bus.led_in = 8'h01;
        tick();
        chk("on_lat1", 32'(bus.led_out), 32'h0);
        tick();
        chk("on_lat2", 32'(bus.led_out), 32'h01);
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("on_hold", 32'(bus.led_out), 32'h01);
        end
        bus.led_in = 8'h00;
        rs = 1'b1;
        tick();
        rs = 1'b0;

        // Fade of ch3 from a single-cycle pulse.
        wait_decay();
        bus.led_in = 8'h08;
        tick();
        bus.led_in = 8'h00;
        measure();
        chk("fade_full", 32'(hi[3]), 32'(eff[15]));
        for (int k = 14; k >= 0; k--) begin
            wait_decay();
            tick();
            measure();
            chk($sformatf("fade_lvl%0d", k), 32'(hi[3]), 32'(eff[k]));
        end
        for (int i = 0; i < 250; i++) begin
            tick();
            chk("fade_dark", 32'(bus.led_out), 32'h0);
        end
        rs = 1'b1;
        tick();
        rs = 1'b0;

        // ch5 set on the same edge as a decay step while at level 7.
        wait_decay();
        bus.led_in = 8'h20;
        tick();
        bus.led_in = 8'h00;
        for (int j = 1; j <= 8; j++) wait_decay();
        tick();
        measure();
        chk("coll_pre_lvl7", 32'(hi[5]), 32'(eff[7]));
        wait_decay();
        bus.led_in = 8'h20;
        tick();
        bus.led_in = 8'h00;
        measure();
        chk("coll_set_wins", 32'(hi[5]), 32'(eff[15]));
        rs = 1'b1;
        tick();
        rs = 1'b0;

        // Build levels {15,9,3} on ch0..2, then reset mid-fade.
        wait_decay();
        bus.led_in = 8'h04;
        tick();
        bus.led_in = 8'h00;
        for (int j = 1; j <= 12; j++) begin
            wait_decay();
            if (j == 6 || j == 12) begin
                bus.led_in = (j == 6) ? 8'h02 : 8'h01;
                tick();
                bus.led_in = 8'h00;
            end
        end
        measure();
        chk("mid_ch0", 32'(hi[0]), 32'(eff[15]));
        chk("mid_ch1", 32'(hi[1]), 32'(eff[9]));
        chk("mid_ch2", 32'(hi[2]), 32'(eff[3]));
        rs = 1'b1;
        tick();
        rs = 1'b0;
        chk("mid_rst_led_out", 32'(bus.led_out), 32'h0);
        chk("mid_rst_frame_tick", 32'(bus.frame_tick), 32'd0);
        chk("mid_rst_decay_tick", 32'(bus.decay_tick), 32'd0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("mid_post_led_out", 32'(bus.led_out), 32'h0);
            chk("mid_post_frame_tick", 32'(bus.frame_tick), (i == 15) ? 32'd1 : 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
